lcd_frame_reader: RTL and testbench
===================================

# lcd_frame_reader

Display-side consumer of the dual-port SDRAM frame buffer controller's read FIFO. It generates LCD/VGA raster timing (HS, VS, DE) from parameterised porch and sync counts. It issues one FIFO read strobe per active pixel so that FIFO data lines up with DE, and pulses the controller's read-load once per frame to flush the read FIFO and rewind the read address. It also drives the controller's read-valid enable once SDRAM initialisation has completed.

## Interface
Parameters:
- H_DISP, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_DISP, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- DSIZE, 32, read FIFO data width; pixel is RD_DATA[23:0], RGB888 with R in bits 23:16

Ports:
- CLK  in  1  pixel clock; also the read-FIFO read clock (RD_CLK)
- RESET  in  1  synchronous, active-high reset
- SDRAM_INIT_DONE  in  1  SDRAM initialisation complete, level
- RD_DATA  in  DSIZE  read FIFO q; non-show-ahead, valid the cycle after RD
- RD  out  1  read FIFO read request
- RD_LOAD  out  1  read FIFO clear and read address reload, one line wide per frame
- SDRAM_READ_VALID  out  1  read enable to the controller
- LCD_HS  out  1  horizontal sync, active low
- LCD_VS  out  1  vertical sync, active low
- LCD_DE  out  1  data enable, active high
- LCD_RGB  out  24  pixel data; 0 whenever LCD_DE=0

## Operation
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT.
  - v_cnt increments when h_cnt wraps, over 0..V_TOTAL-1.
  - Both are 12 bits, free-running from reset, and wrap to 0.
- Line order is sync, back porch, active, front porch. The same order applies to the frame.
- Active window:
  - HA = [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP)
  - VA = [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP)
  - act = h_cnt in HA and v_cnt in VA.
- State machine (2-bit register, reset to IDLE):
  - IDLE: SDRAM_READ_VALID=0. Go to WAIT_FRAME on the first cycle SDRAM_INIT_DONE=1.
  - WAIT_FRAME: SDRAM_READ_VALID=1. Go to RUN when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, i.e. at the frame boundary.
  - RUN: SDRAM_READ_VALID=1. Stays in RUN until reset. A later drop of SDRAM_INIT_DONE is ignored.
- RD = act and state==RUN. RD is decoded combinationally from the registered counters and state.
- RD_LOAD = (v_cnt==0) in every state, registered. It is therefore high for the whole of line 0, which lies inside VS.
- Syncs and DE are generated in every state. Before RUN, LCD_RGB=0 and DE still toggles, so the panel sees blank frames.

## Timing
- Reset values:
  - RD=0, RD_LOAD=0, SDRAM_READ_VALID=0.
  - LCD_HS=1, LCD_VS=1, LCD_DE=0, LCD_RGB=0.
  - h_cnt=0, v_cnt=0.
- Reset mid-frame: all of the above take effect on the next edge. After reset the block re-waits for SDRAM_INIT_DONE and then a full frame boundary.
- RD to data: RD asserted in cycle t gives RD_DATA valid in t+1.
- LCD outputs carry 2 cycles of latency from the counter state:
  - LCD_DE, LCD_HS and LCD_VS are the counter decodes (HS = h_cnt<H_SYNC, VS = v_cnt<V_SYNC, DE = act), delayed through two register stages.
  - LCD_RGB <= RD_DATA[23:0] when stage-1 DE and RUN are both true, else 0. This aligns LCD_RGB with LCD_DE.
- Each active line produces exactly H_DISP RD pulses, contiguous. Each frame produces H_DISP*V_DISP RD pulses.
- RD_LOAD and RD are never high in the same cycle, because V_SYNC+V_BACK >= 1.
- FIFO underflow is not detected. The controller keeps the FIFO filled ahead of consumption.

## Configuration
- LCD_TEST_PATTERN_EN: when defined, RD is held 0 and LCD_RGB shows 8 vertical colour bars, each H_DISP/8 pixels wide.
  - Bar order, left to right: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - The pattern is shown in every state, including IDLE.
  - RD_LOAD, SDRAM_READ_VALID and all timing are unchanged.
- When the macro is not defined, behaviour is as described in Operation.

## Test plan
Small parameters for all scenarios: H_DISP=8, H_FRONT=2, H_SYNC=2, H_BACK=2 (H_TOTAL=14); V_DISP=4, V_FRONT=1, V_SYNC=1, V_BACK=1 (V_TOTAL=7).

- Reset check: hold RESET for 3 clocks, then release with SDRAM_INIT_DONE=0 -> all outputs at reset values; RD=0 for 2 full frames (196 clocks); LCD_DE pulses 8 clocks per active line.
- Startup: raise SDRAM_INIT_DONE at clock 30 -> SDRAM_READ_VALID=1 from clock 31; first RD at h_cnt=4, v_cnt=2 of the next frame; 32 RD pulses per frame after that.
- Data alignment: RD_DATA = 0xAA000000 + read index -> LCD_RGB sequence 000000..000007 exactly under the 8 LCD_DE-high cycles of the line; the first pixel appears 2 clocks after h_cnt=4.
- RD_LOAD: RD_LOAD is high exactly 14 clocks per frame, coincident with LCD_VS low (allowing for the 2-cycle skew), and never overlaps RD.
- Reset mid-line: assert RESET while RD=1 -> RD=0 on the next edge; after release, no RD until SDRAM_INIT_DONE is seen and a frame boundary passes.
- With LCD_TEST_PATTERN_EN defined: RD stays 0; the active line shows FFFFFF at pixel 0 and 000000 at pixel 7.

Source files
------------

// File: rtl/lcd_frame_reader.sv
// lcd_frame_reader: LCD raster timing plus read-FIFO consumer for the SDRAM frame buffer.
// Define LCD_TEST_PATTERN_EN to replace FIFO pixels with 8 vertical colour bars.
module lcd_frame_reader #(
    parameter int H_DISP  = 640,
    parameter int H_FRONT = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int V_DISP  = 480,
    parameter int V_FRONT = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int DSIZE   = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SDRAM_INIT_DONE,
    input  logic [DSIZE-1:0] RD_DATA,
    output logic             RD,
    output logic             RD_LOAD,
    output logic             SDRAM_READ_VALID,
    output logic             LCD_HS,
    output logic             LCD_VS,
    output logic             LCD_DE,
    output logic [23:0]      LCD_RGB
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int HA_S    = H_SYNC + H_BACK;
    localparam int HA_E    = HA_S + H_DISP;
    localparam int VA_S    = V_SYNC + V_BACK;
    localparam int VA_E    = VA_S + V_DISP;

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, RUN} state_t;

    state_t      state, state_nxt;
    logic [11:0] h_cnt, v_cnt;
    logic        h_end, v_end, act, run;
    logic        hs1, vs1, de1;
    logic [23:0] rgb_nxt;

    assign h_end = h_cnt == 12'(H_TOTAL - 1);
    assign v_end = v_cnt == 12'(V_TOTAL - 1);
    assign act   = h_cnt >= 12'(HA_S) && h_cnt < 12'(HA_E) && v_cnt >= 12'(VA_S) && v_cnt < 12'(VA_E);
    assign run   = state == RUN;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_end ? '0 : h_cnt + 12'd1;
            if (h_end)
                v_cnt <= v_end ? '0 : v_cnt + 12'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // RUN is only entered on a frame boundary so the FIFO rewind lines up with pixel 0
    always_comb begin
        state_nxt        = state;
        SDRAM_READ_VALID = 1'b0;
        case (state)
            IDLE:       if (SDRAM_INIT_DONE) state_nxt = WAIT_FRAME;
            WAIT_FRAME: begin
                SDRAM_READ_VALID = 1'b1;
                if (h_end && v_end) state_nxt = RUN;
            end
            RUN:        SDRAM_READ_VALID = 1'b1;
            default:    state_nxt = IDLE;
        endcase
    end

`ifdef LCD_TEST_PATTERN_EN
    localparam int BAR_W = H_DISP >= 8 ? H_DISP / 8 : 1;

    logic [11:0] x1, bar;
    logic [2:0]  bi;
    logic        unused_data;

    assign RD          = 1'b0;
    assign unused_data = ^{RD_DATA, run};
    assign bar         = x1 / 12'(BAR_W);
    assign bi          = bar > 12'd7 ? 3'd7 : bar[2:0];
    assign rgb_nxt     = de1 ? {{8{~bi[1]}}, {8{~bi[2]}}, {8{~bi[0]}}} : 24'h0;

    always_ff @(posedge CLK) begin
        if (RESET)
            x1 <= '0;
        else
            x1 <= h_cnt - 12'(HA_S);
    end
`else
    logic unused_data;

    assign RD          = act && run;
    assign unused_data = ^RD_DATA[DSIZE-1:24];
    assign rgb_nxt     = de1 && run ? RD_DATA[23:0] : 24'h0;
`endif

    // Two register stages so DE/syncs match the one-cycle FIFO read latency plus the RGB register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hs1     <= 1'b1;
            vs1     <= 1'b1;
            de1     <= 1'b0;
            LCD_HS  <= 1'b1;
            LCD_VS  <= 1'b1;
            LCD_DE  <= 1'b0;
            LCD_RGB <= '0;
            RD_LOAD <= 1'b0;
        end else begin
            hs1     <= h_cnt >= 12'(H_SYNC);
            vs1     <= v_cnt >= 12'(V_SYNC);
            de1     <= act;
            LCD_HS  <= hs1;
            LCD_VS  <= vs1;
            LCD_DE  <= de1;
            LCD_RGB <= rgb_nxt;
            RD_LOAD <= v_cnt == 12'd0;
        end
    end
endmodule

// File: tb/tb_lcd_frame_reader.sv
// tb_lcd_frame_reader: table checkpoints plus a FIFO scoreboard for lcd_frame_reader.
module tb_lcd_frame_reader;
`ifdef LCD_TEST_PATTERN_EN
    localparam bit PAT = 1'b1;
`else
    localparam bit PAT = 1'b0;
`endif
    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FR = HT * VT;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        SDRAM_INIT_DONE = 1'b0;
    logic [31:0] RD_DATA = 32'h0;
    logic        RD, RD_LOAD, SDRAM_READ_VALID, LCD_HS, LCD_VS, LCD_DE;
    logic [23:0] LCD_RGB;

    int total = 0;
    int bad = 0;

    lcd_frame_reader #(
        .H_DISP(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISP(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .DSIZE(32)
    ) dut (
        .CLK(CLK), .RESET(RESET), .SDRAM_INIT_DONE(SDRAM_INIT_DONE), .RD_DATA(RD_DATA),
        .RD(RD), .RD_LOAD(RD_LOAD), .SDRAM_READ_VALID(SDRAM_READ_VALID),
        .LCD_HS(LCD_HS), .LCD_VS(LCD_VS), .LCD_DE(LCD_DE), .LCD_RGB(LCD_RGB)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
        end
    endtask

    function automatic logic [23:0] bar(input int i);
        logic [23:0] c [8];
        c = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return (i >= 0 && i < 8) ? c[i] : 24'h0;
    endfunction

    // scoreboard: expected pixels pushed when RD is seen, popped under LCD_DE
    initial begin : mon
        logic [23:0] q [$];
        int n, st, st_f, rd_f, ld_f, de_f, de_run, rd_idx, h, v;
        bit pend, prev_ld;
        logic [23:0] exp_rgb;
        logic [31:0] pend_val;
        n = 0; st = 0; st_f = 0; rd_f = 0; ld_f = 0; de_f = 0; de_run = 0; rd_idx = 0;
        pend = 0; prev_ld = 0; pend_val = 0;
        forever begin
            @(negedge CLK);
            pend = 0;
            if (RESET) begin
                n = 0; st = 0; rd_f = 0; ld_f = 0; de_f = 0; de_run = 0; rd_idx = 0;
                q.delete();
            end else begin
                h = n % HT;
                v = (n / HT) % VT;
                if (n % FR == 0) begin
                    if (n > 0) begin
                        chk("rd_per_frame", rd_f, (st_f == 2 && !PAT) ? 32 : 0);
                        chk("load_per_frame", ld_f, 14);
                        chk("de_per_frame", de_f, 32);
                    end
                    st_f = st; rd_f = 0; ld_f = 0; de_f = 0;
                end
                chk("rd_load_overlap", int'(RD && RD_LOAD), 0);
                if (n >= 2) chk("vs_vs_load", int'(LCD_VS), int'(!prev_ld));
                if (LCD_DE) begin
                    exp_rgb = PAT ? bar(de_run) : (q.size() > 0 ? q.pop_front() : 24'h0);
                    de_run++;
                end else begin
                    if (de_run != 0) chk("de_run", de_run, 8);
                    de_run = 0;
                    exp_rgb = 24'h0;
                end
                chk("rgb", int'(LCD_RGB), int'(exp_rgb));
                rd_f += int'(RD); ld_f += int'(RD_LOAD); de_f += int'(LCD_DE);
                if (RD) begin
                    q.push_back(24'(rd_idx % 8));
                    pend_val = 32'hAA000000 | 32'(rd_idx % 8);
                    pend = 1;
                    rd_idx++;
                end
                if (st == 0 && SDRAM_INIT_DONE) st = 1;
                else if (st == 1 && h == HT - 1 && v == VT - 1) st = 2;
                prev_ld = RD_LOAD;
                n++;
            end
            @(posedge CLK);
            #1;
            if (pend) RD_DATA = pend_val;
        end
    end

    typedef struct {
        int         n;
        logic [5:0] e;
    } vec_t;

    initial begin : main
        vec_t tbl [20];
        int cur;
        logic [5:0] got, want;
        // {rd, rd_load, read_valid, hs, vs, de}, n = cycles since release; INIT_DONE rises at n=30
        tbl = '{
            '{0,   6'b000110}, '{1,   6'b010110}, '{2,   6'b010000}, '{30,  6'b000010},
            '{31,  6'b001010}, '{34,  6'b001111}, '{98,  6'b001110}, '{99,  6'b011110},
            '{100, 6'b011000}, '{112, 6'b011100}, '{113, 6'b001100}, '{114, 6'b001010},
            '{129, 6'b001010}, '{130, 6'b101110}, '{132, 6'b101111}, '{137, 6'b101111},
            '{138, 6'b001111}, '{139, 6'b001111}, '{140, 6'b001110}, '{141, 6'b001110}
        };

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_outs", int'({RD, RD_LOAD, SDRAM_READ_VALID, LCD_HS, LCD_VS, LCD_DE}), int'(6'b000110));
        chk("reset_rgb", int'(LCD_RGB), 0);

        // two blank frames with SDRAM never ready
        @(posedge CLK); #1; RESET = 1'b0;
        repeat (200) @(posedge CLK);
        #1; RESET = 1'b1;
        repeat (3) @(posedge CLK);

        #1; RESET = 1'b0; cur = 0;
        for (int i = 0; i < 20; i++) begin
            while (cur < tbl[i].n) begin
                @(posedge CLK); #1; cur++;
                if (cur == 30) SDRAM_INIT_DONE = 1'b1;
            end
            #2;
            got  = {RD, RD_LOAD, SDRAM_READ_VALID, LCD_HS, LCD_VS, LCD_DE};
            want = tbl[i].e;
            if (PAT) want[5] = 1'b0;
            chk($sformatf("vec n=%0d", tbl[i].n), int'(got), int'(want));
        end

        // a drop of INIT_DONE while running must be ignored
        while (cur < 426) begin
            @(posedge CLK); #1; cur++;
            if (cur == 300) SDRAM_INIT_DONE = 1'b0;
        end
        RESET = 1'b1;
        #2;
        chk("rd_before_reset_edge", int'(RD), PAT ? 0 : 1);
        @(posedge CLK); #3;
        chk("midreset_outs", int'({RD, RD_LOAD, SDRAM_READ_VALID, LCD_HS, LCD_VS, LCD_DE}), int'(6'b000110));
        chk("midreset_rgb", int'(LCD_RGB), 0);
        RESET = 1'b0; cur = 0;
        while (cur < 300) begin
            @(posedge CLK); #1; cur++;
            if (cur == 150) SDRAM_INIT_DONE = 1'b1;
            if (cur < 196) begin
                #2; chk("no_rd_before_boundary", int'(RD), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
